// File: rtl/video_pkg.sv
// video_pkg
//   Shared definitions for the video line prefetcher:
//   - fetch_state_t : row-fetch FSM states
//   - WORDS_MAX / COL_W : line-buffer geometry for the default 1024-pixel,
//     2-pixels-per-word configuration
//   - words_max_of / col_w_of : the same derivations for any configuration
package video_pkg;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_REQ  = 2'd1,
    FETCH_FILL = 2'd2,
    FETCH_DONE = 2'd3
  } fetch_state_t;

  localparam int DEF_H_ACTIVE     = 1024;
  localparam int DEF_PIX_PER_WORD = 2;

  function automatic int words_max_of(input int h_active, input int pix_per_word);
    return h_active / pix_per_word;
  endfunction

  function automatic int col_w_of(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

  localparam int WORDS_MAX = words_max_of(DEF_H_ACTIVE, DEF_PIX_PER_WORD);
  localparam int COL_W     = col_w_of(WORDS_MAX);

endpackage

// File: rtl/line_buffer_dp.sv
// line_buffer_dp
//   Simple dual-port line RAM: one synchronous write port, one read port
//   with a registered output (one cycle read latency). Contents are never
//   reset.
// Ports:
//   i_master_clk : clock
//   i_wr_en      : write strobe
//   i_wr_addr    : write word address
//   i_wr_data    : write data
//   i_rd_addr    : read word address (sampled every cycle)
//   o_rd_data    : registered read data
module line_buffer_dp #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 10
) (
  input  logic              i_master_clk,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge i_master_clk) begin
    if (i_wr_en) begin
      mem[i_wr_addr] <= i_wr_data;
    end
    o_rd_data <= mem[i_rd_addr];
  end

endmodule

// File: rtl/video_line_prefetcher.sv
// video_line_prefetcher
//   Prefetches one VRAM source row per display line into a ping-pong line
//   buffer and streams pixels out as RGB. In 2x mode every source pixel is
//   shown twice and every source row is shown on two consecutive lines.
// Ports:
//   i_master_clk, i_reset            : clock, async active-high reset
//   i_system_video_bank/scale_mode   : latched at i_frame_start
//   i_frame_start, i_line_start      : frame / line strobes
//   i_video_active                   : consume one output pixel
//   o_video_red/green/blue           : pixel components, 2-cycle latency
//   o_vram_display_address/start     : row-fetch request (start is 1 cycle)
//   i_vram_display_column/data/valid : returned VRAM words
//   o_underrun                       : sticky, a swap found the fill incomplete
module video_line_prefetcher
  import video_pkg::*;
#(
  parameter int H_ACTIVE     = 1024,
  parameter int V_ACTIVE     = 600,
  parameter int PIX_BITS     = 12,
  parameter int PIX_PER_WORD = 2,
  parameter int ROW_STRIDE   = 512,
  parameter int ADDR_W       = 20
) (
  input  logic                                        i_master_clk,
  input  logic                                        i_reset,
  input  logic                                        i_system_video_bank,
  input  logic                                        i_system_scale_mode,
  input  logic                                        i_frame_start,
  input  logic                                        i_line_start,
  input  logic                                        i_video_active,
  output logic [PIX_BITS/3-1:0]                       o_video_red,
  output logic [PIX_BITS/3-1:0]                       o_video_green,
  output logic [PIX_BITS/3-1:0]                       o_video_blue,
  output logic [ADDR_W-1:0]                           o_vram_display_address,
  output logic                                        o_vram_display_start,
  input  logic [col_w_of(H_ACTIVE/PIX_PER_WORD)-1:0]  i_vram_display_column,
  input  logic [PIX_BITS*PIX_PER_WORD-1:0]            i_vram_display_data,
  input  logic                                        i_vram_display_data_valid,
  output logic                                        o_underrun
);

  localparam int LINE_WORDS = words_max_of(H_ACTIVE, PIX_PER_WORD);
  localparam int LINE_COL_W = col_w_of(LINE_WORDS);
  localparam int LOG_PPW    = $clog2(PIX_PER_WORD);
  localparam int SUB_W      = (PIX_PER_WORD > 1) ? LOG_PPW : 1;
  localparam int PTR_W      = $clog2(H_ACTIVE + 1);
  localparam int ROW_W      = $clog2(V_ACTIVE + 1);
  localparam int WORD_W     = PIX_BITS * PIX_PER_WORD;
  localparam int COMP_W     = PIX_BITS / 3;
  localparam logic [ADDR_W-2:0] STRIDE_LO = (ADDR_W-1)'(ROW_STRIDE);

  // ---------------- fetch side ----------------
  fetch_state_t state_reg, state_next;

  logic              bank_reg;
  logic              scale_reg;
  logic [ADDR_W-1:0] row_addr_reg;
  logic [ROW_W-1:0]  row_idx_reg;
  logic              wr_half_reg;
  logic              rd_half_reg;
  logic              line_odd_reg;
  logic              underrun_reg;

  logic [ROW_W-1:0]      src_rows;
  logic [LINE_COL_W-1:0] words_last;
  logic                  rows_remain;
  logic                  fetching;
  logic                  swap_due;
  logic                  wr_en;

  assign src_rows    = scale_reg ? ROW_W'(V_ACTIVE / 2) : ROW_W'(V_ACTIVE);
  assign words_last  = scale_reg ? LINE_COL_W'(LINE_WORDS / 2 - 1)
                                 : LINE_COL_W'(LINE_WORDS - 1);
  assign rows_remain = (row_idx_reg + ROW_W'(1)) < src_rows;
  assign fetching    = (state_reg == FETCH_REQ) || (state_reg == FETCH_FILL);

  // In 2x mode only even lines bring in a new source row. Once every row
  // of the frame has been fetched (IDLE) there is nothing left to swap in.
  assign swap_due = i_line_start && !i_frame_start &&
                    (state_reg != FETCH_IDLE) &&
                    (!scale_reg || !line_odd_reg);

  // A word arriving in the cycle the fill is aborted would land in the half
  // that has just become the display half, so it is dropped.
  assign wr_en = i_vram_display_data_valid && (state_reg == FETCH_FILL) &&
                 !swap_due && !i_frame_start;

  always_comb begin
    state_next           = state_reg;
    o_vram_display_start = 1'b0;
    case (state_reg)
      FETCH_IDLE: state_next = FETCH_IDLE;
      FETCH_REQ: begin
        o_vram_display_start = 1'b1;
        state_next           = FETCH_FILL;
      end
      FETCH_FILL: begin
        if (i_vram_display_data_valid && (i_vram_display_column == words_last)) begin
          state_next = FETCH_DONE;
        end
      end
      FETCH_DONE: state_next = FETCH_DONE;
      default:    state_next = FETCH_IDLE;
    endcase
    if (swap_due) begin
      state_next = rows_remain ? FETCH_REQ : FETCH_IDLE;
    end
    if (i_frame_start) begin
      state_next = FETCH_REQ;
    end
  end

  always_ff @(posedge i_master_clk or posedge i_reset) begin
    if (i_reset) begin
      state_reg    <= FETCH_IDLE;
      bank_reg     <= 1'b0;
      scale_reg    <= 1'b0;
      row_addr_reg <= '0;
      row_idx_reg  <= '0;
      wr_half_reg  <= 1'b0;
      rd_half_reg  <= 1'b0;
      line_odd_reg <= 1'b0;
      underrun_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (i_frame_start) begin
        bank_reg     <= i_system_video_bank;
        scale_reg    <= i_system_scale_mode;
        row_addr_reg <= {i_system_video_bank, {(ADDR_W-1){1'b0}}};
        row_idx_reg  <= '0;
        wr_half_reg  <= 1'b0;
        line_odd_reg <= 1'b0;
        underrun_reg <= 1'b0;
      end else begin
        if (i_line_start) begin
          line_odd_reg <= ~line_odd_reg;
        end
        if (swap_due) begin
          rd_half_reg <= wr_half_reg;
          wr_half_reg <= ~wr_half_reg;
          if (fetching) begin
            underrun_reg <= 1'b1;
          end
          if (rows_remain) begin
            row_idx_reg  <= row_idx_reg + ROW_W'(1);
            // The address wraps inside the bank; the bank bit never changes.
            row_addr_reg <= {bank_reg, row_addr_reg[ADDR_W-2:0] + STRIDE_LO};
          end
        end
      end
    end
  end

  assign o_vram_display_address = row_addr_reg;
  assign o_underrun             = underrun_reg;

  // ---------------- display side ----------------
  logic [PTR_W-1:0]      rd_ptr_reg;
  logic                  dbl_reg;
  logic [PTR_W-1:0]      pix_limit;
  logic                  rd_in_range;
  logic [LINE_COL_W-1:0] rd_word_idx;
  logic [SUB_W-1:0]      rd_sub;
  logic [WORD_W-1:0]     rd_word;
  logic                  s1_valid_reg;
  logic [SUB_W-1:0]      s1_sub_reg;
  logic [PIX_BITS-1:0]   pixel_reg;
  logic [PIX_BITS-1:0]   word_pix [PIX_PER_WORD];

  assign pix_limit   = scale_reg ? PTR_W'(H_ACTIVE / 2) : PTR_W'(H_ACTIVE);
  assign rd_in_range = rd_ptr_reg < pix_limit;
  assign rd_word_idx = LINE_COL_W'(rd_ptr_reg >> LOG_PPW);
  assign rd_sub      = (PIX_PER_WORD > 1) ? SUB_W'(rd_ptr_reg) : '0;

  // Pointer counts source pixels; it saturates at the end of the line so
  // surplus actives read nothing instead of wrapping to pixel 0.
  always_ff @(posedge i_master_clk or posedge i_reset) begin
    if (i_reset) begin
      rd_ptr_reg <= '0;
      dbl_reg    <= 1'b0;
    end else if (i_line_start) begin
      rd_ptr_reg <= '0;
      dbl_reg    <= 1'b0;
    end else if (i_video_active && rd_in_range) begin
      if (!scale_reg || dbl_reg) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      if (scale_reg) begin
        dbl_reg <= ~dbl_reg;
      end
    end
  end

  line_buffer_dp #(
    .DATA_W (WORD_W),
    .ADDR_W (LINE_COL_W + 1)
  ) u_line_buffer (
    .i_master_clk (i_master_clk),
    .i_wr_en      (wr_en),
    .i_wr_addr    ({wr_half_reg, i_vram_display_column}),
    .i_wr_data    (i_vram_display_data),
    .i_rd_addr    ({rd_half_reg, rd_word_idx}),
    .o_rd_data    (rd_word)
  );

  // Pixel 0 occupies the LSBs of each word.
  generate
    for (genvar gi = 0; gi < PIX_PER_WORD; gi++) begin : g_word_pix
      assign word_pix[gi] = rd_word[gi*PIX_BITS +: PIX_BITS];
    end
  endgenerate

  // Stage 1 tracks the RAM read register; stage 2 is the demux register.
  always_ff @(posedge i_master_clk or posedge i_reset) begin
    if (i_reset) begin
      s1_valid_reg <= 1'b0;
      s1_sub_reg   <= '0;
      pixel_reg    <= '0;
    end else begin
      s1_valid_reg <= i_video_active && rd_in_range;
      s1_sub_reg   <= rd_sub;
      pixel_reg    <= s1_valid_reg ? word_pix[s1_sub_reg] : '0;
    end
  end

  assign o_video_red   = pixel_reg[2*COMP_W +: COMP_W];
  assign o_video_green = pixel_reg[COMP_W +: COMP_W];
  assign o_video_blue  = pixel_reg[0 +: COMP_W];

endmodule
